div: RTL and testbench



---
 rtl/div.sv | 161 ++++++++++++++++
 tb/tb_div.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div.sv
// Sequential unsigned restoring divider, one quotient bit per clock, runtime operand width.
// Optional zero-divisor short-circuit enabled by defining DIV_ZERO_DETECT_EN.
module div #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          op_enable,
  input  logic [$clog2(DATA_WIDTH):0]   in_width,
  input  logic [DATA_WIDTH-1:0]         in_div_a,
  input  logic [DATA_WIDTH-1:0]         in_div_b,
  output logic [DATA_WIDTH-1:0]         out_quotient,
  output logic [DATA_WIDTH-1:0]         out_remainder,
  output logic                          out_div_by_zero,
  output logic                          op_finish
);

  localparam int WW = $clog2(DATA_WIDTH) + 1;
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

`ifdef DIV_ZERO_DETECT_EN
  localparam bit DZ_EN = 1'b1;
`else
  localparam bit DZ_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [DATA_WIDTH-1:0] rem_q, rem_d;
  logic [DATA_WIDTH-1:0] quo_q, quo_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  dz_q, dz_d;
  logic [DATA_WIDTH-1:0] out_quo_q, out_quo_d;
  logic [DATA_WIDTH-1:0] out_rem_q, out_rem_d;
  logic                  out_dz_q, out_dz_d;
  logic                  finish_q, finish_d;

  logic [WW-1:0]         w_eff;
  logic [DATA_WIDTH-1:0] op_mask;
  logic [DATA_WIDTH-1:0] a_masked;
  logic [DATA_WIDTH-1:0] b_masked;
  logic                  zero_div;
  logic [DATA_WIDTH:0]   r_shift;
  logic [DATA_WIDTH+1:0] diff;
  logic                  borrow;

  always_comb begin
    w_eff = in_width;
    if (in_width == '0 || in_width > WW'(DATA_WIDTH)) begin
      w_eff = WW'(DATA_WIDTH);
    end
  end

  // Bit gi of an operand survives the load only when it lies below the effective width.
  generate
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_mask
      assign op_mask[gi] = (w_eff > WW'(gi));
    end
  endgenerate

  assign a_masked = in_div_a & op_mask;
  assign b_masked = in_div_b & op_mask;
  assign zero_div = DZ_EN && (b_masked == '0);

  // The partial remainder is always below the divisor, so DATA_WIDTH bits hold it after each step.
  assign r_shift = {rem_q, a_q[idx_q]};
  assign diff    = {1'b0, r_shift} - {2'b00, b_q};
  assign borrow  = diff[DATA_WIDTH+1];

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    idx_d     = idx_q;
    dz_d      = dz_q;
    out_quo_d = out_quo_q;
    out_rem_d = out_rem_q;
    out_dz_d  = out_dz_q;
    finish_d  = finish_q;

    if (!op_enable) begin
      state_d   = IDLE;
      out_quo_d = '0;
      out_rem_d = '0;
      out_dz_d  = 1'b0;
      finish_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          a_d   = a_masked;
          b_d   = b_masked;
          rem_d = '0;
          quo_d = '0;
          idx_d = IW'(w_eff - WW'(1));
          dz_d  = 1'b0;
          if (zero_div) begin
            dz_d    = 1'b1;
            rem_d   = a_masked;
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
        RUN: begin
          rem_d = borrow ? r_shift[DATA_WIDTH-1:0] : diff[DATA_WIDTH-1:0];
          quo_d = {quo_q[DATA_WIDTH-2:0], ~borrow};
          idx_d = idx_q - IW'(1);
          if (idx_q == '0) begin
            state_d = DONE;
          end
        end
        DONE: begin
          out_quo_d = quo_q;
          out_rem_d = rem_q;
          out_dz_d  = dz_q;
          finish_d  = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      idx_q     <= '0;
      dz_q      <= 1'b0;
      out_quo_q <= '0;
      out_rem_q <= '0;
      out_dz_q  <= 1'b0;
      finish_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      idx_q     <= idx_d;
      dz_q      <= dz_d;
      out_quo_q <= out_quo_d;
      out_rem_q <= out_rem_d;
      out_dz_q  <= out_dz_d;
      finish_q  <= finish_d;
    end
  end

  assign out_quotient    = out_quo_q;
  assign out_remainder   = out_rem_q;
  assign out_div_by_zero = out_dz_q;
  assign op_finish       = finish_q;

endmodule

// File: tb/tb_div.sv
// Directed self-checking bench for div (DATA_WIDTH = 32); expectations follow DIV_ZERO_DETECT_EN.
module tb_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_enable;
  logic [5:0]  in_width;
  logic [31:0] in_div_a;
  logic [31:0] in_div_b;
  logic [31:0] out_quotient;
  logic [31:0] out_remainder;
  logic        out_div_by_zero;
  logic        op_finish;

  int checks = 0;
  int errors = 0;

  div #(.DATA_WIDTH(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .op_enable       (op_enable),
    .in_width        (in_width),
    .in_div_a        (in_div_a),
    .in_div_b        (in_div_b),
    .out_quotient    (out_quotient),
    .out_remainder   (out_remainder),
    .out_div_by_zero (out_div_by_zero),
    .op_finish       (op_finish)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [5:0] w, input logic [31:0] a, input logic [31:0] b);
    in_width  = w;
    in_div_a  = a;
    in_div_b  = b;
    op_enable = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1; op_enable = 1'b0; in_width = '0; in_div_a = '0; in_div_b = '0;
    tick(2);
    checks++;
    if ({op_finish, out_div_by_zero} !== 2'b00 || out_quotient !== 32'h0 || out_remainder !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs got fin=%b dz=%b q=%h r=%h required all 0",
               op_finish, out_div_by_zero, out_quotient, out_remainder);
    end
    rst = 1'b0;
    tick(1);
    $display("TXN reset fin=%b q=%h r=%h", op_finish, out_quotient, out_remainder);
  endtask

  task automatic test_basic;
    start_op(6'd8, 32'd100, 32'd7);
    tick(9);
    checks++;
    if (op_finish !== 1'b0) begin
      errors++; $display("FAIL basic_early_finish got %b required 0 at edge 9", op_finish);
    end
    tick(1);
    checks++;
    if (op_finish !== 1'b1 || out_quotient !== 32'd14 || out_remainder !== 32'd2 || out_div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL basic_result got fin=%b q=%0d r=%0d dz=%b required fin=1 q=14 r=2 dz=0",
               op_finish, out_quotient, out_remainder, out_div_by_zero);
    end
    tick(3);
    checks++;
    if (op_finish !== 1'b1 || out_quotient !== 32'd14 || out_remainder !== 32'd2) begin
      errors++;
      $display("FAIL basic_hold got fin=%b q=%0d r=%0d required fin=1 q=14 r=2",
               op_finish, out_quotient, out_remainder);
    end
    op_enable = 1'b0;
    tick(1);
    checks++;
    if (op_finish !== 1'b0 || out_quotient !== 32'h0 || out_remainder !== 32'h0) begin
      errors++;
      $display("FAIL basic_clear got fin=%b q=%h r=%h required all 0", op_finish, out_quotient, out_remainder);
    end
    $display("TXN basic w=8 a=100 b=7 -> q=14 r=2");
  endtask

  task automatic test_mask;
    start_op(6'd4, 32'hF3, 32'h12);
    tick(2);
    in_div_a = 32'h0; in_div_b = 32'h1; in_width = 6'd8;
    tick(3);
    checks++;
    if (op_finish !== 1'b0) begin
      errors++; $display("FAIL mask_early_finish got %b required 0 at edge 5", op_finish);
    end
    tick(1);
    checks++;
    if (op_finish !== 1'b1 || out_quotient !== 32'h1 || out_remainder !== 32'h1) begin
      errors++;
      $display("FAIL mask_result got fin=%b q=%h r=%h required fin=1 q=00000001 r=00000001",
               op_finish, out_quotient, out_remainder);
    end
    op_enable = 1'b0;
    tick(1);
    $display("TXN mask w=4 a=f3 b=12 -> q=1 r=1");
  endtask

  task automatic test_full_width;
    start_op(6'd0, 32'hFFFF_FFFF, 32'h1);
    tick(33);
    checks++;
    if (op_finish !== 1'b0) begin
      errors++; $display("FAIL full_early_finish got %b required 0 at edge 33", op_finish);
    end
    tick(1);
    checks++;
    if (op_finish !== 1'b1 || out_quotient !== 32'hFFFF_FFFF || out_remainder !== 32'h0) begin
      errors++;
      $display("FAIL full_max got fin=%b q=%h r=%h required fin=1 q=ffffffff r=00000000",
               op_finish, out_quotient, out_remainder);
    end
    op_enable = 1'b0;
    tick(1);
    $display("TXN full w=0(32) a=ffffffff b=1 -> q=ffffffff r=0");
    start_op(6'd40, 32'd5, 32'd9);
    tick(34);
    checks++;
    if (op_finish !== 1'b1 || out_quotient !== 32'h0 || out_remainder !== 32'd5) begin
      errors++;
      $display("FAIL full_small got fin=%b q=%h r=%h required fin=1 q=0 r=5",
               op_finish, out_quotient, out_remainder);
    end
    op_enable = 1'b0;
    tick(1);
    $display("TXN full w=40(32) a=5 b=9 -> q=0 r=5");
  endtask

  task automatic test_div_zero;
    start_op(6'd8, 32'h2A, 32'h0);
`ifdef DIV_ZERO_DETECT_EN
    tick(2);
    checks++;
    if (op_finish !== 1'b1 || out_div_by_zero !== 1'b1 || out_quotient !== 32'h0 || out_remainder !== 32'h2A) begin
      errors++;
      $display("FAIL dz_detect got fin=%b dz=%b q=%h r=%h required fin=1 dz=1 q=0 r=2a",
               op_finish, out_div_by_zero, out_quotient, out_remainder);
    end
`else
    tick(9);
    checks++;
    if (op_finish !== 1'b0) begin
      errors++; $display("FAIL dz_early_finish got %b required 0 at edge 9", op_finish);
    end
    tick(1);
    checks++;
    if (op_finish !== 1'b1 || out_div_by_zero !== 1'b0 || out_quotient !== 32'hFF || out_remainder !== 32'h2A) begin
      errors++;
      $display("FAIL dz_natural got fin=%b dz=%b q=%h r=%h required fin=1 dz=0 q=ff r=2a",
               op_finish, out_div_by_zero, out_quotient, out_remainder);
    end
`endif
    op_enable = 1'b0;
    tick(1);
    $display("TXN divzero w=8 a=2a b=0 q=%h r=%h dz=%b", out_quotient, out_remainder, out_div_by_zero);
  endtask

  task automatic test_abort;
    start_op(6'd16, 32'd1000, 32'd7);
    tick(4);
    op_enable = 1'b0;
    tick(1);
    checks++;
    if (op_finish !== 1'b0 || out_quotient !== 32'h0 || out_remainder !== 32'h0) begin
      errors++;
      $display("FAIL abort_clear got fin=%b q=%h r=%h required all 0", op_finish, out_quotient, out_remainder);
    end
    start_op(6'd16, 32'd50000, 32'd123);
    tick(17);
    checks++;
    if (op_finish !== 1'b0) begin
      errors++; $display("FAIL abort_early_finish got %b required 0 at edge 17", op_finish);
    end
    tick(1);
    checks++;
    if (op_finish !== 1'b1 || out_quotient !== 32'd406 || out_remainder !== 32'd62) begin
      errors++;
      $display("FAIL abort_restart got fin=%b q=%0d r=%0d required fin=1 q=406 r=62",
               op_finish, out_quotient, out_remainder);
    end
    op_enable = 1'b0;
    tick(1);
    $display("TXN abort w=16 restart a=50000 b=123 -> q=406 r=62");
  endtask

  task automatic test_async_reset;
    start_op(6'd8, 32'd200, 32'd9);
    tick(10);
    checks++;
    if (op_finish !== 1'b1 || out_quotient !== 32'd22 || out_remainder !== 32'd2) begin
      errors++;
      $display("FAIL rst_pre_result got fin=%b q=%0d r=%0d required fin=1 q=22 r=2",
               op_finish, out_quotient, out_remainder);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (op_finish !== 1'b0 || out_quotient !== 32'h0 || out_remainder !== 32'h0) begin
      errors++;
      $display("FAIL rst_immediate got fin=%b q=%h r=%h required all 0", op_finish, out_quotient, out_remainder);
    end
    start_op(6'd8, 32'd60, 32'd7);
    rst = 1'b0;
    tick(4);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (op_finish !== 1'b0 || out_quotient !== 32'h0) begin
      errors++; $display("FAIL rst_midrun got fin=%b q=%h required 0", op_finish, out_quotient);
    end
    start_op(6'd8, 32'd90, 32'd8);
    rst = 1'b0;
    tick(9);
    checks++;
    if (op_finish !== 1'b0) begin
      errors++; $display("FAIL rst_early_finish got %b required 0 at edge 9", op_finish);
    end
    tick(1);
    checks++;
    if (op_finish !== 1'b1 || out_quotient !== 32'd11 || out_remainder !== 32'd2) begin
      errors++;
      $display("FAIL rst_fresh_result got fin=%b q=%0d r=%0d required fin=1 q=11 r=2",
               op_finish, out_quotient, out_remainder);
    end
    op_enable = 1'b0;
    tick(1);
    $display("TXN async_reset fresh a=90 b=8 -> q=11 r=2");
  endtask

  task automatic test_back_to_back;
    start_op(6'd8, 32'd255, 32'd16);
    tick(10);
    checks++;
    if (op_finish !== 1'b1 || out_quotient !== 32'd15 || out_remainder !== 32'd15) begin
      errors++;
      $display("FAIL b2b_first got fin=%b q=%0d r=%0d required fin=1 q=15 r=15",
               op_finish, out_quotient, out_remainder);
    end
    op_enable = 1'b0;
    tick(1);
    checks++;
    if (op_finish !== 1'b0) begin
      errors++; $display("FAIL b2b_gap got %b required 0", op_finish);
    end
    start_op(6'd8, 32'd77, 32'd77);
    tick(10);
    checks++;
    if (op_finish !== 1'b1 || out_quotient !== 32'd1 || out_remainder !== 32'd0) begin
      errors++;
      $display("FAIL b2b_second got fin=%b q=%0d r=%0d required fin=1 q=1 r=0",
               op_finish, out_quotient, out_remainder);
    end
    op_enable = 1'b0;
    tick(1);
    $display("TXN back_to_back 255/16 -> 15 r15, 77/77 -> 1 r0");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mask();
    test_full_width();
    test_div_zero();
    test_abort();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
